// File: rtl/nibble_acc_pkg.sv
// rtl/nibble_acc_pkg.sv - shared types and widths for the nibble accumulator
// Purpose: frame state encoding and datapath/counter widths used by
//          nibble_accumulator.
// Contents: DATA_W, CNT_W, acc_state_t {ACCUM, DONE}.
package nibble_acc_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/nibble_accumulator_adder.sv
// rtl/nibble_accumulator_adder.sv - 4-bit Han-Carlson prefix adder (sum only)
// Purpose: combinational 4-bit adder, modulo-16 result.
// Ports:
//   a   in  4  operand
//   b   in  4  operand
//   sum out 4  (a + b) mod 16
module Han_Carlson_Adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum
);

    logic [3:0] g;
    logic [3:0] p;
    logic       g10;
    logic       g20;

    assign g = a & b;
    assign p = a ^ b;

    // Odd-bit prefix stage: group generate for bits 1:0.
    assign g10 = g[1] | (p[1] & g[0]);

    // Even-bit fix-up stage: bit 2 borrows the odd-position group result.
    // The carry out of bit 3 is not formed; the parent detects wrap itself.
    assign g20 = g[2] | (p[2] & g10);

    assign sum = p ^ {g20, g10, g[0], 1'b0};

endmodule

// File: rtl/nibble_accumulator.sv
// rtl/nibble_accumulator.sv - framed 4-bit accumulator around Han_Carlson_Adder
// Purpose: accepts COUNT operands per frame over valid/ready, presents the
//          registered frame total and a sticky overflow flag.
// Optional feature: define NIBBLE_ACC_SATURATE_EN to clamp the accumulator
//          at 15 on wrap instead of wrapping modulo 16.
// Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   clear     in   1  synchronous frame abort
//   in_valid  in   1  operand valid
//   in_ready  out  1  operand accepted this cycle
//   in_data   in   4  unsigned operand
//   out_valid out  1  frame result valid
//   out_ready in   1  downstream takes result
//   out_sum   out  4  frame total
//   out_ovf   out  1  frame overflow flag
module nibble_accumulator
    import nibble_acc_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf
);

    acc_state_t        state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] add_sum;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              wrap;
    logic              ovf_next;
    logic              accept;
    logic              last_beat;

    Han_Carlson_Adder u_adder (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum)
    );

    // A modulo sum smaller than the old accumulator means the add wrapped.
    assign wrap = add_sum < acc;

`ifdef NIBBLE_ACC_SATURATE_EN
    // Once at 15 any nonzero add wraps again, so the clamp holds by itself.
    assign acc_next = wrap ? {DATA_W{1'b1}} : add_sum;
`else
    assign acc_next = add_sum;
`endif

    assign ovf_next  = ovf | wrap;
    assign in_ready  = (state == ACCUM) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CNT_W'(COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf_next;
                        if (last_beat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_ovf   <= ovf_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
